// File: rtl/avalon_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : avalon_mem_responder
// Brief    : Avalon-MM slave RAM with programmable wait states and a
//            side-band load port for preloading contents.
// Revision : 1.0 - initial release
// ============================================================================
module avalon_mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int         c_DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] c_WAIT_LAST = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] readdata_q, readdata_d;
    logic        err_q, err_d;

    logic                  w_req;
    logic                  w_both;
    logic                  w_one;
    logic                  w_bus_wr;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [ADDR_WIDTH-1:0] w_load_idx;
    logic [31:0]           w_rd_word;
    logic                  w_unused;

    assign w_req      = read | write;
    assign w_both     = read & write;
    assign w_one      = read ^ write;
    assign w_idx      = address[ADDR_WIDTH+1:2];
    assign w_load_idx = load_addr[ADDR_WIDTH+1:2];
    // Upper address bits alias and load addresses are word-aligned by contract.
    assign w_unused   = ^{address[31:ADDR_WIDTH+2], load_addr[31:ADDR_WIDTH+2], load_addr[1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            readdata_q <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            readdata_q <= readdata_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        readdata_d = readdata_q;
        err_d      = err_q;
        w_bus_wr   = 1'b0;

        if (w_both || (w_one && address[1:0] != 2'b00)) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (w_one && !load_en) begin
                    cnt_d = 4'd0;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_ACK;
                        if (read) begin
                            readdata_d = w_rd_word;
                        end
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A load freezes the access in place; the master keeps stalling.
                if (!load_en) begin
                    if (!w_one) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == c_WAIT_LAST) begin
                            state_d = S_ACK;
                            if (read) begin
                                readdata_d = w_rd_word;
                            end
                        end
                    end
                end
            end
            S_ACK: begin
                if (!load_en) begin
                    state_d  = S_IDLE;
                    w_bus_wr = write & ~read;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign waitrequest = ~reset_n | (w_req & ~w_both & (load_en | (state_q != S_ACK)));
    assign readdata    = readdata_q;
    assign err         = err_q;

    // One byte-wide array per lane keeps partial writes a plain lane enable.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] mem_q [c_DEPTH];

        always_ff @(posedge clk) begin
            if (load_en) begin
                mem_q[w_load_idx] <= load_data[8*g +: 8];
            end else if (w_bus_wr && reset_n && byteenable[g]) begin
                mem_q[w_idx] <= writedata[8*g +: 8];
            end
        end

        assign w_rd_word[8*g +: 8] = mem_q[w_idx];
    end

endmodule
`default_nettype wire

// File: tb/tb_avalon_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_mem_responder
// Brief    : Scoreboard bench for avalon_mem_responder with a word-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_mem_responder;

    localparam int AW = 8;
    localparam int WC = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] address = 32'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [3:0]  byteenable = 4'd0;
    logic [31:0] writedata = 32'd0;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        err;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = 32'd0;
    logic [31:0] load_data = 32'd0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model_mem [1 << AW];
    logic [31:0] exp_q [$];

    avalon_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .read(read),
        .write(write), .byteenable(byteenable), .writedata(writedata),
        .waitrequest(waitrequest), .readdata(readdata), .err(err),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every read acknowledge pops the oldest expected word.
    always @(negedge clk) begin
        if (reset_n && read && !write && !waitrequest) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL read_ack: got 0x%08h with nothing expected", readdata);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (readdata !== e) begin
                    n_errors++;
                    $display("FAIL read_data @0x%08h: got 0x%08h expected 0x%08h", address, readdata, e);
                end
            end
        end
    end

    // Starts and ends one cycle after a rising edge; loads (if any) overlap the first n_load cycles.
    task automatic do_access(input bit is_wr, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wd, input int n_load,
                             input logic [31:0] laddr, input logic [31:0] ldata);
        int stall;
        int cyc;
        int w;
        w = int'(addr[AW+1:2]);
        if (n_load > 0) model_mem[laddr[AW+1:2]] = ldata;
        if (!is_wr) exp_q.push_back(model_mem[w]);
        address = addr; read = ~is_wr; write = is_wr; byteenable = be; writedata = wd;
        load_en = (n_load > 0); load_addr = laddr; load_data = ldata;
        stall = 0;
        cyc = 0;
        forever begin
            if (cyc == n_load) load_en = 1'b0;
            @(negedge clk);
            if (!waitrequest) break;
            stall++;
            if (stall > 40) begin
                $display("FAIL ack_timeout: got no ack after %0d cycles", stall);
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("stall_cycles", 32'(stall), 32'(n_load + WC + 1));
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0; load_en = 1'b0;
        if (is_wr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) model_mem[w][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    task automatic rd(input logic [31:0] addr);
        do_access(1'b0, addr, 4'hF, 32'd0, 0, 32'd0, 32'd0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        do_access(1'b1, addr, be, wd, 0, 32'd0, 32'd0);
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] data);
        load_en = 1'b1; load_addr = addr; load_data = data;
        model_mem[addr[AW+1:2]] = data;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("reset_waitrequest", 32'(waitrequest), 32'd1);
        chk("reset_readdata", readdata, 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        #10 reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < (1 << AW); i++) load(32'(i) << 2, $urandom());

        // Preloaded program word read back with WC+1 stall cycles
        load(32'h04, 32'h24020010);
        rd(32'h04);
        chk("err_after_clean_read", 32'(err), 32'd0);

        // Byte-lane merge
        load(32'h08, 32'h11223344);
        wr(32'h08, 4'b0101, 32'hAABBCCDD);
        rd(32'h08);

        // Write abandoned during WAIT leaves memory untouched
        load(32'h0C, 32'h00000008);
        address = 32'h0C; write = 1'b1; byteenable = 4'hF; writedata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        write = 1'b0;
        @(posedge clk); #1;
        rd(32'h0C);

        // read and write together
        address = 32'h04; read = 1'b1; write = 1'b1; writedata = 32'h0; byteenable = 4'hF;
        @(negedge clk);
        chk("both_waitrequest", 32'(waitrequest), 32'd0);
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
        chk("both_err", 32'(err), 32'd1);
        rd(32'h04);
        chk("err_sticky", 32'(err), 32'd1);

        // Reset in the middle of a write
        address = 32'h10; write = 1'b1; byteenable = 4'hF; writedata = ~model_mem[4];
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("midreset_waitrequest", 32'(waitrequest), 32'd1);
        chk("midreset_readdata", readdata, 32'd0);
        chk("midreset_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        write = 1'b0;
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        rd(32'h10);

        // Misaligned address uses the word index and flags an error
        rd(32'h05);
        chk("misaligned_err", 32'(err), 32'd1);

        // Load held 3 cycles during a read of the same word
        do_access(1'b0, 32'h20, 4'hF, 32'd0, 3, 32'h20, 32'hCAFEF00D);
        // Load and bus write to the same word: load first, write lands afterwards
        do_access(1'b1, 32'h24, 4'b0011, 32'h12345678, 1, 32'h24, 32'hA5A5A5A5);
        rd(32'h24);

        // Randomized traffic with aliased upper address bits and sporadic loads
        for (int t = 0; t < 150; t++) begin
            logic [31:0] a;
            logic [31:0] la;
            int nl;
            a  = ($urandom() & 32'hFFFF_FC00) | (32'($urandom_range(0, (1 << AW) - 1)) << 2);
            la = 32'($urandom_range(0, (1 << AW) - 1)) << 2;
            nl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            do_access(1'($urandom_range(0, 1)), a, 4'($urandom()), $urandom(), nl, la, $urandom());
        end
        for (int t = 0; t < 20; t++) rd(32'($urandom_range(0, (1 << AW) - 1)) << 2);

        chk("err_final", 32'(err), 32'd1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
